// File: rtl/ciphertext_packer.sv
// rtl/ciphertext_packer.sv - packs LANES ciphertext values per word into a DEPTH-word output FIFO
// Optional macro PACK_PRECHARGE_EN: zero-precharge cycle after each pop, assembly cleared after each push.
module ciphertext_packer #(
   parameter int WIDTH = 8,
   parameter int LANES = 4,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   input  logic [WIDTH-1:0]           in_data,
   input  logic                       flush,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH*LANES-1:0]     out_data,
   output logic [$clog2(LANES):0]     out_lanes,
   output logic [$clog2(DEPTH):0]     fifo_level,
   output logic                       overflow,
   input  logic                       clear_ovf
);
   localparam int LW = $clog2(LANES) + 1;
   localparam int PW = $clog2(DEPTH);
   localparam int FW = PW + 1;
   localparam int DW = WIDTH * LANES;

   logic [LW-1:0] lane_cnt;
   logic [LW-1:0] push_lanes;
   logic [DW-1:0] asm_q;
   logic [DW-1:0] asm_d;
   logic [DW-1:0] push_word;
   logic [DW-1:0] data_mem [DEPTH];
   logic [LW-1:0] lanes_mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          push;
   logic          pop;
   logic          full;
   logic          empty;
   logic          store;
   logic          drop;
   logic          hold;

   always_comb begin
      asm_d = asm_q;
      for (int i = 0; i < LANES; i++) begin
         if (in_valid && lane_cnt == LW'(i)) asm_d[i*WIDTH +: WIDTH] = in_data;
      end
      push_lanes = lane_cnt + LW'(in_valid);
      push = (in_valid && lane_cnt == LW'(LANES - 1)) || (flush && push_lanes != '0);
      // lanes beyond the filled count are zero-padded so stale assembly lanes never leak
      push_word = '0;
      for (int i = 0; i < LANES; i++) begin
         if (LW'(i) < push_lanes) push_word[i*WIDTH +: WIDTH] = asm_d[i*WIDTH +: WIDTH];
      end
   end

   always_comb begin
      empty     = (fifo_level == '0);
      full      = (fifo_level == FW'(DEPTH));
      out_valid = !empty && !hold;
      pop       = out_valid && out_ready;
      store     = push && (!full || pop);
      drop      = push && full && !pop;
      out_data  = out_valid ? data_mem[rd_ptr] : '0;
      out_lanes = out_valid ? lanes_mem[rd_ptr] : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lane_cnt   <= '0;
         asm_q      <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
         overflow   <= 1'b0;
         hold       <= 1'b0;
      end else begin
         if (push) lane_cnt <= '0;
         else if (in_valid) lane_cnt <= lane_cnt + LW'(1);
`ifdef PACK_PRECHARGE_EN
         asm_q <= push ? '0 : asm_d;
         hold  <= pop;
`else
         asm_q <= asm_d;
         hold  <= 1'b0;
`endif
         if (store) wr_ptr <= wr_ptr + PW'(1);
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         case ({store, pop})
            2'b10:   fifo_level <= fifo_level + FW'(1);
            2'b01:   fifo_level <= fifo_level - FW'(1);
            default: fifo_level <= fifo_level;
         endcase
         // a drop on the same edge as clear_ovf keeps the flag set
         if (drop) overflow <= 1'b1;
         else if (clear_ovf) overflow <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (store) begin
         data_mem[wr_ptr]  <= push_word;
         lanes_mem[wr_ptr] <= push_lanes;
      end
   end

endmodule

// File: tb/tb_ciphertext_packer.sv
// tb/tb_ciphertext_packer.sv - randomized and directed checks of ciphertext_packer against a queue model
module tb_ciphertext_packer;
   localparam int W = 8;
   localparam int L = 4;
   localparam int D = 4;

   logic          clk = 0;
   logic          rst = 1;
   logic          in_valid = 0;
   logic [W-1:0]  in_data = 0;
   logic          flush = 0;
   logic          out_valid;
   logic          out_ready = 0;
   logic [W*L-1:0] out_data;
   logic [2:0]    out_lanes;
   logic [2:0]    fifo_level;
   logic          overflow;
   logic          clear_ovf = 0;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic [W*L-1:0] d;
      int             n;
   } word_t;

   word_t      q[$];
   logic [W-1:0] part[$];
   bit         m_ovf = 0;
   bit         m_pre = 0;

   ciphertext_packer #(.WIDTH(W), .LANES(L), .DEPTH(D)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_lanes(out_lanes), .fifo_level(fifo_level), .overflow(overflow),
      .clear_ovf(clear_ovf)
   );

   always #5 clk = ~clk;

   function automatic void chk(string name, longint act, longint exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   always @(posedge clk or posedge rst) begin
      bit    pop;
      bit    push;
      bit    drop;
      word_t w;
      if (rst) begin
         q.delete();
         part.delete();
         m_ovf = 0;
         m_pre = 0;
      end else begin
         pop = (q.size() > 0) && !m_pre && out_ready;
         if (in_valid) part.push_back(in_data);
         push = (part.size() == L) || (flush && part.size() > 0);
         drop = 0;
         if (pop) void'(q.pop_front());
         if (push) begin
            w.d = '0;
            foreach (part[i]) w.d[i*W +: W] = part[i];
            w.n = part.size();
            part.delete();
            if (q.size() < D) q.push_back(w);
            else drop = 1;
         end
         if (drop) m_ovf = 1;
         else if (clear_ovf) m_ovf = 0;
`ifdef PACK_PRECHARGE_EN
         m_pre = pop;
`endif
      end
   end

   always @(negedge clk) begin
      bit             mv;
      logic [W*L-1:0] md;
      int             ml;
      mv = (q.size() > 0) && !m_pre;
      md = '0;
      ml = 0;
      if (mv) begin
         md = q[0].d;
         ml = q[0].n;
      end
      chk("out_valid", out_valid, mv);
      chk("out_data", out_data, md);
      chk("out_lanes", out_lanes, ml);
      chk("fifo_level", fifo_level, q.size());
      chk("overflow", overflow, m_ovf);
   end

   task automatic put(input logic v, input logic [W-1:0] d, input logic f,
                      input logic r, input logic c);
      in_valid  = v;
      in_data   = d;
      flush     = f;
      out_ready = r;
      clear_ovf = c;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [4:0] hs;
      logic [4:0] exp_hs;

      repeat (3) @(posedge clk);
      #1;
      chk("reset_valid", out_valid, 0);
      chk("reset_level", fifo_level, 0);
      rst = 0;

      put(1, 8'h11, 0, 0, 0);
      put(1, 8'h22, 0, 0, 0);
      put(1, 8'h33, 0, 0, 0);
      put(1, 8'h44, 0, 0, 0);
      chk("pack_valid", out_valid, 1);
      chk("pack_data", out_data, 32'h44332211);
      chk("pack_lanes", out_lanes, 4);
      chk("pack_level", fifo_level, 1);
      put(0, 0, 0, 1, 0);

      put(1, 8'hAA, 0, 0, 0);
      put(1, 8'hBB, 0, 0, 0);
      put(0, 0, 1, 0, 0);
      chk("flush_data", out_data, 32'h0000BBAA);
      chk("flush_lanes", out_lanes, 2);
      put(0, 0, 0, 1, 0);
      put(0, 0, 1, 0, 0);
      chk("flush_noop_level", fifo_level, 0);

      for (int i = 1; i <= 20; i++) put(1, W'(i), 0, 0, 0);
      chk("ovf_level", fifo_level, 4);
      chk("ovf_flag", overflow, 1);
      chk("ovf_head", out_data, 32'h04030201);
      put(0, 0, 0, 0, 1);
      chk("ovf_clear", overflow, 0);

      put(1, 8'd21, 0, 0, 0);
      put(1, 8'd22, 0, 0, 0);
      put(1, 8'd23, 0, 0, 0);
      put(1, 8'd24, 0, 1, 0);
      chk("fullpp_ovf", overflow, 0);
      chk("fullpp_level", fifo_level, 4);
      put(0, 0, 0, 0, 0);
      chk("fullpp_head", out_data, 32'h08070605);
      for (int i = 0; i < 12; i++) put(0, 0, 0, 1, 0);
      chk("drain_level", fifo_level, 0);

      for (int i = 0; i < 8; i++) put(1, W'(8'h31 + i), 0, 0, 0);
      in_valid  = 0;
      out_ready = 1;
      for (int k = 0; k < 5; k++) begin
         hs[k] = out_valid;
         @(posedge clk);
         #1;
      end
`ifdef PACK_PRECHARGE_EN
      exp_hs = 5'b00101;
`else
      exp_hs = 5'b00011;
`endif
      chk("handshake_pattern", hs, exp_hs);

      for (int i = 0; i < 6; i++) put(1, W'(8'h60 + i), 0, 0, 0);
      put(0, 0, 0, 0, 0);
      rst = 1;
      #1;
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_lanes", out_lanes, 0);
      chk("rst_level", fifo_level, 0);
      chk("rst_ovf", overflow, 0);
      @(posedge clk);
      #1;
      rst = 0;
      put(1, 8'h51, 0, 0, 0);
      put(1, 8'h52, 0, 0, 0);
      put(1, 8'h53, 0, 0, 0);
      put(1, 8'h54, 0, 0, 0);
      chk("post_rst_data", out_data, 32'h54535251);
      chk("post_rst_lanes", out_lanes, 4);

      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 499) == 0) begin
            in_valid = 0;
            rst = 1;
            @(posedge clk);
            #1;
            rst = 0;
         end
         put(($urandom_range(0, 9) < 7), W'($urandom), ($urandom_range(0, 9) == 0),
             $urandom_range(0, 1) == 1, ($urandom_range(0, 19) == 0));
      end
      put(0, 0, 0, 0, 0);
      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
